icache_2way: RTL

Parametrised 2-way set-associative instruction cache that replaces the fixed 4-line direct-mapped cache used in the fetch path.
- Sits between the PC/fetch stage and instruction memory.
- CPU side uses a valid/ready request and a registered response; memory side uses a valid/ready line-refill handshake.
- Adds LRU replacement, a walking flush/invalidate, and hit/miss performance counters.

---
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_tag_way.sv | 46 ++++
 rtl/icache_2way.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the 2-way instruction cache.
// Field helpers work on a widened address so any parameter set can reuse them.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  // Byte offset is always two bits (32-bit instruction words).
  function automatic logic [63:0] f_word(input logic [63:0] a, input int word_w);
    return (a >> 2) & ((64'd1 << word_w) - 64'd1);
  endfunction

  function automatic logic [63:0] f_index(input logic [63:0] a, input int word_w,
                                          input int index_w);
    return (a >> (2 + word_w)) & ((64'd1 << index_w) - 64'd1);
  endfunction

  function automatic logic [63:0] f_tag(input logic [63:0] a, input int word_w,
                                        input int index_w);
    return a >> (2 + word_w + index_w);
  endfunction

endpackage

// File: rtl/icache_tag_way.sv
// One cache way: tag, valid and line storage in flops with a combinational
// compare port, a line-write port and a single-set clear port.
module icache_tag_way #(
  parameter int NUM_SETS = 4,
  parameter int TAG_W    = 26,
  parameter int LINE_W   = 128
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_SETS)-1:0] i_idx,
  input  logic [TAG_W-1:0]            i_tag,
  output logic                        o_hit,
  output logic                        o_valid,
  output logic [LINE_W-1:0]           o_line,
  input  logic                        i_wr_en,
  input  logic [LINE_W-1:0]           i_wr_line,
  input  logic                        i_clr_en,
  input  logic [$clog2(NUM_SETS)-1:0] i_clr_idx
);

  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [LINE_W-1:0]   r_data [NUM_SETS];

  assign o_valid = r_valid[i_idx];
  assign o_hit   = r_valid[i_idx] && (r_tag[i_idx] == i_tag);
  assign o_line  = r_data[i_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      if (i_clr_en) r_valid[i_clr_idx] <= 1'b0;
      if (i_wr_en)  r_valid[i_idx]     <= 1'b1;
    end
  end

  // Tag and data need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_idx]  <= i_tag;
      r_data[i_idx] <= i_wr_line;
    end
  end

endmodule

// File: rtl/icache_2way.sv
// 2-way set-associative instruction cache with LRU replacement, walking
// flush, line refill handshake and saturating hit/miss counters.
module icache_2way
  import icache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_SETS       = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cpu_req_valid,
  input  logic [ADDR_W-1:0]                cpu_req_addr,
  output logic                             cpu_req_ready,
  output logic                             cpu_rsp_valid,
  output logic [DATA_W-1:0]                cpu_rsp_data,
  output logic                             stall,
  input  logic                             flush,
  output logic                             mem_req_valid,
  output logic [ADDR_W-1:0]                mem_req_addr,
  input  logic                             mem_req_ready,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_W*WORDS_PER_LINE-1:0] mem_rsp_data,
  output logic                             hit_pulse,
  output logic                             miss_pulse,
  output logic [CNT_W-1:0]                 hit_count,
  output logic [CNT_W-1:0]                 miss_count
);

  localparam int LINE_W  = DATA_W * WORDS_PER_LINE;
  localparam int WORD_W  = $clog2(WORDS_PER_LINE);
  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W   = ADDR_W - 2 - WORD_W - INDEX_W;
  localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(NUM_SETS - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [NUM_SETS-1:0] r_lru;
  logic [INDEX_W-1:0]  r_fcnt;
  logic                r_flush_pend;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_hit_pulse;
  logic                r_miss_pulse;
  logic [CNT_W-1:0]    r_hit_count;
  logic [CNT_W-1:0]    r_miss_count;

  logic [ADDR_W-1:0]      w_lk_addr;
  logic [INDEX_W-1:0]     w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic [WORD_W-1:0]      w_word;
  logic [1:0]             w_hit_way;
  logic [1:0]             w_vld;
  logic [1:0]             w_wr_en;
  logic [LINE_W-1:0]      w_line [2];
  logic                   w_hit;
  logic                   w_hit_sel;
  logic                   w_victim;
  logic                   w_fill;
  logic [LINE_W-1:0]      w_sel_line;
  logic [DATA_W-1:0]      w_hit_word;
  logic [DATA_W-1:0]      w_fill_word;

  // In IDLE the lookup follows the incoming request; otherwise the latched miss.
  assign w_lk_addr = (r_state == IDLE) ? cpu_req_addr : r_addr;
  assign w_idx     = INDEX_W'(f_index(64'(w_lk_addr), WORD_W, INDEX_W));
  assign w_tag     = TAG_W'(f_tag(64'(w_lk_addr), WORD_W, INDEX_W));
  assign w_word    = WORD_W'(f_word(64'(w_lk_addr), WORD_W));

  assign w_hit       = |w_hit_way;
  assign w_hit_sel   = w_hit_way[1];
  assign w_victim    = !w_vld[0] ? 1'b0 : (!w_vld[1] ? 1'b1 : r_lru[w_idx]);
  assign w_fill      = (r_state == MISS_WAIT) && mem_rsp_valid;
  assign w_sel_line  = w_line[w_hit_sel];
  assign w_hit_word  = w_sel_line[DATA_W*w_word +: DATA_W];
  assign w_fill_word = mem_rsp_data[DATA_W*w_word +: DATA_W];

  for (genvar g = 0; g < 2; g++) begin : g_way
    assign w_wr_en[g] = w_fill && (w_victim == 1'(g));
    icache_tag_way #(
      .NUM_SETS (NUM_SETS),
      .TAG_W    (TAG_W),
      .LINE_W   (LINE_W)
    ) u_way (
      .clk       (clk),
      .reset     (reset),
      .i_idx     (w_idx),
      .i_tag     (w_tag),
      .o_hit     (w_hit_way[g]),
      .o_valid   (w_vld[g]),
      .o_line    (w_line[g]),
      .i_wr_en   (w_wr_en[g]),
      .i_wr_line (mem_rsp_data),
      .i_clr_en  (r_state == FLUSH),
      .i_clr_idx (r_fcnt)
    );
  end

  assign cpu_req_ready = (r_state == IDLE) && !flush && !reset;
  assign stall         = (r_state != IDLE);
  assign mem_req_valid = (r_state == MISS_REQ);
  assign mem_req_addr  = {r_addr[ADDR_W-1:2+WORD_W], {(2+WORD_W){1'b0}}};
  assign cpu_rsp_valid = r_rsp_valid;
  assign cpu_rsp_data  = r_rsp_data;
  assign hit_pulse     = r_hit_pulse;
  assign miss_pulse    = r_miss_pulse;
  assign hit_count     = r_hit_count;
  assign miss_count    = r_miss_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_lru        <= '0;
      r_fcnt       <= '0;
      r_flush_pend <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
    end else begin
      r_rsp_valid  <= 1'b0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (flush) begin
            r_state <= FLUSH;
            r_fcnt  <= '0;
          end else if (cpu_req_valid) begin
            if (w_hit) begin
              r_rsp_valid   <= 1'b1;
              r_rsp_data    <= w_hit_word;
              r_lru[w_idx]  <= ~w_hit_sel;
              r_hit_pulse   <= 1'b1;
            end else begin
              r_addr       <= cpu_req_addr;
              r_miss_pulse <= 1'b1;
              r_state      <= MISS_REQ;
            end
          end
        end
        MISS_REQ: begin
          if (flush) r_flush_pend <= 1'b1;
          if (mem_req_ready) r_state <= MISS_WAIT;
        end
        MISS_WAIT: begin
          if (mem_rsp_valid) begin
            r_lru[w_idx] <= ~w_victim;
            r_rsp_valid  <= 1'b1;
            r_rsp_data   <= w_fill_word;
            if (r_flush_pend || flush) begin
              r_state      <= FLUSH;
              r_fcnt       <= '0;
              r_flush_pend <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else if (flush) begin
            r_flush_pend <= 1'b1;
          end
        end
        FLUSH: begin
          r_lru[r_fcnt] <= 1'b0;
          if (r_fcnt == LAST_SET) begin
            // A flush that arrived during the walk restarts it straight away.
            if (r_flush_pend || flush) begin
              r_fcnt       <= '0;
              r_flush_pend <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
            if (flush) r_flush_pend <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Always assigned so the saturating add also reloads from the current value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_hit_count  <= r_hit_count  + CNT_W'(r_hit_pulse  && !(&r_hit_count));
      r_miss_count <= r_miss_count + CNT_W'(r_miss_pulse && !(&r_miss_count));
    end
  end

endmodule
